// File: rtl/xillylite_regfile_pkg.sv
// Shared constants for the Xillybus Lite register file: control-page word map,
// default ID value and the read-source selector used by the output mux.
package xillylite_regfile_pkg;

  localparam int CTL_ID      = 0;
  localparam int CTL_ISTAT   = 1;
  localparam int CTL_IEN     = 2;
  localparam int CTL_DBELL   = 3;
  localparam int CTL_STATUS0 = 4;

  localparam logic [31:0] ID_DEFAULT = 32'h584C_5232;

  typedef enum logic [1:0] {
    SRC_ZERO = 2'd0,
    SRC_RAM  = 2'd1,
    SRC_CTL  = 2'd2
  } rd_src_e;

endpackage

// File: rtl/xillylite_regfile_if.sv
// Xillybus Lite user_* bus as seen by a register file: the processor side is
// the master, the register file is the slave.
interface xillylite_regfile_if;

  logic [31:0] user_addr;
  logic        user_wren;
  logic [3:0]  user_wstrb;
  logic [31:0] user_wr_data;
  logic        user_rden;
  logic [31:0] user_rd_data;
  logic        user_irq;

  modport master (
    output user_addr, user_wren, user_wstrb, user_wr_data, user_rden,
    input  user_rd_data, user_irq
  );

  modport slave (
    input  user_addr, user_wren, user_wstrb, user_wr_data, user_rden,
    output user_rd_data, user_irq
  );

endinterface

// File: rtl/xillylite_byte_ram.sv
// Single-port 32-bit RAM with per-byte write enables and a registered,
// read-first output that holds its value when no read is requested.
module xillylite_byte_ram #(
  parameter int ADDR_BITS = 5
) (
  input  logic                 i_clk,
  input  logic                 i_wr_en,
  input  logic [3:0]           i_wstrb,
  input  logic [ADDR_BITS-1:0] i_addr,
  input  logic [31:0]          i_wr_data,
  input  logic                 i_rd_en,
  output logic [31:0]          o_rd_data
);

  logic [3:0][7:0] r_mem [2**ADDR_BITS];
  logic [31:0]     r_rdData;

  // No reset on purpose: contents must survive a user_rst_n pulse.
  always_ff @(posedge i_clk) begin
    if (i_rd_en) begin
      r_rdData <= r_mem[i_addr];
    end
    for (int b = 0; b < 4; b++) begin
      if (i_wr_en && i_wstrb[b]) begin
        r_mem[i_addr][b] <= i_wr_data[8*b +: 8];
      end
    end
  end

  assign o_rd_data = r_rdData;

endmodule

// File: rtl/xillylite_regfile.sv
// Xillybus Lite register file: page 0 is byte-lane scratch RAM, page 1 holds
// ID, W1C interrupt status, interrupt enable, doorbell and read-only status words.
module xillylite_regfile
  import xillylite_regfile_pkg::*;
#(
  parameter int          ADDR_BITS  = 5,
  parameter int          NUM_IRQ    = 8,
  parameter int          NUM_STATUS = 4,
  parameter logic [31:0] ID_VALUE   = ID_DEFAULT
) (
  input  logic                      i_user_clk,
  input  logic                      i_user_rst_n,
  xillylite_regfile_if.slave        bus,
  input  logic [NUM_IRQ-1:0]        i_irq_event,
  input  logic [32*((NUM_STATUS > 0) ? NUM_STATUS : 1)-1:0] i_status_in,
  output logic                      o_doorbell_pulse,
  output logic [31:0]               o_doorbell_data
);

  logic [ADDR_BITS-1:0] w_word;
  logic                 w_page;
  logic [31:0]          w_laneMask;
  logic                 w_ctlWr;
  logic                 w_wrIstat;
  logic                 w_wrIen;
  logic                 w_wrDbell;
  logic                 w_ramWr;
  logic                 w_ramRd;
  logic [NUM_IRQ-1:0]   w_istatNext;
  logic [NUM_IRQ-1:0]   w_ienNext;
  logic [31:0]          w_ctlRdData;
  logic [31:0]          w_ramQ;
  logic                 w_unused;

  logic [NUM_IRQ-1:0]   r_istat;
  logic [NUM_IRQ-1:0]   r_ien;
  logic                 r_irq;
  logic [31:0]          r_dbell;
  logic                 r_dbPulse;
  logic [31:0]          r_ctlRdData;
  rd_src_e              r_rdSrc;

  assign w_word     = bus.user_addr[ADDR_BITS+1:2];
  assign w_page     = bus.user_addr[ADDR_BITS+2];
  assign w_laneMask = {{8{bus.user_wstrb[3]}}, {8{bus.user_wstrb[2]}},
                       {8{bus.user_wstrb[1]}}, {8{bus.user_wstrb[0]}}};
  assign w_unused   = ^{bus.user_addr[31:ADDR_BITS+3], bus.user_addr[1:0]};

  assign w_ctlWr   = i_user_rst_n && bus.user_wren && w_page;
  assign w_wrIstat = w_ctlWr && (w_word == ADDR_BITS'(CTL_ISTAT));
  assign w_wrIen   = w_ctlWr && (w_word == ADDR_BITS'(CTL_IEN));
  assign w_wrDbell = w_ctlWr && (w_word == ADDR_BITS'(CTL_DBELL));
  assign w_ramWr   = i_user_rst_n && bus.user_wren && !w_page;
  assign w_ramRd   = i_user_rst_n && bus.user_rden && !w_page;

  // Clear is applied before the OR so a same-cycle event beats its W1C.
  assign w_istatNext = (r_istat & ~(w_wrIstat ?
                        (bus.user_wr_data[NUM_IRQ-1:0] & w_laneMask[NUM_IRQ-1:0]) :
                        {NUM_IRQ{1'b0}})) | i_irq_event;
  assign w_ienNext   = w_wrIen ?
                       ((r_ien & ~w_laneMask[NUM_IRQ-1:0]) |
                        (bus.user_wr_data[NUM_IRQ-1:0] & w_laneMask[NUM_IRQ-1:0])) :
                       r_ien;

  always_comb begin
    w_ctlRdData = '0;
    if (w_word == ADDR_BITS'(CTL_ID)) begin
      w_ctlRdData = ID_VALUE;
    end else if (w_word == ADDR_BITS'(CTL_ISTAT)) begin
      w_ctlRdData = 32'(r_istat);
    end else if (w_word == ADDR_BITS'(CTL_IEN)) begin
      w_ctlRdData = 32'(r_ien);
    end else if (w_word == ADDR_BITS'(CTL_DBELL)) begin
      w_ctlRdData = r_dbell;
    end else begin
      for (int k = 0; k < NUM_STATUS; k++) begin
        if ((CTL_STATUS0 + k < 2**ADDR_BITS) &&
            (w_word == ADDR_BITS'(CTL_STATUS0 + k))) begin
          w_ctlRdData = i_status_in[32*k +: 32];
        end
      end
    end
  end

  // Control reads are captured from pre-write state; the irq flop looks at next state.
  always_ff @(posedge i_user_clk) begin
    if (!i_user_rst_n) begin
      r_istat     <= '0;
      r_ien       <= '0;
      r_irq       <= 1'b0;
      r_dbell     <= '0;
      r_dbPulse   <= 1'b0;
      r_ctlRdData <= '0;
      r_rdSrc     <= SRC_ZERO;
    end else begin
      r_istat   <= w_istatNext;
      r_ien     <= w_ienNext;
      r_irq     <= |(w_istatNext & w_ienNext);
      r_dbPulse <= w_wrDbell && (|bus.user_wstrb);
      if (w_wrDbell) begin
        r_dbell <= (r_dbell & ~w_laneMask) | (bus.user_wr_data & w_laneMask);
      end
      if (bus.user_rden) begin
        r_rdSrc <= w_page ? SRC_CTL : SRC_RAM;
        if (w_page) begin
          r_ctlRdData <= w_ctlRdData;
        end
      end
    end
  end

  xillylite_byte_ram #(
    .ADDR_BITS (ADDR_BITS)
  ) u_ram (
    .i_clk     (i_user_clk),
    .i_wr_en   (w_ramWr),
    .i_wstrb   (bus.user_wstrb),
    .i_addr    (w_word),
    .i_wr_data (bus.user_wr_data),
    .i_rd_en   (w_ramRd),
    .o_rd_data (w_ramQ)
  );

  assign bus.user_rd_data = (r_rdSrc == SRC_RAM) ? w_ramQ :
                            (r_rdSrc == SRC_CTL) ? r_ctlRdData : 32'h0;
  assign bus.user_irq     = r_irq;
  assign o_doorbell_pulse = r_dbPulse;
  assign o_doorbell_data  = r_dbell;

endmodule

// File: tb/tb_xillylite_regfile.sv
// Randomised scoreboard bench for xillylite_regfile against a word-level
// behavioural model of the scratch page and control page.
module tb_xillylite_regfile;

  localparam logic [31:0] ID_VAL = 32'h584C_5232;

  logic         clk = 1'b0;
  logic         rstN;
  logic [7:0]   irqEvent;
  logic [127:0] statusIn;
  logic         dbPulse;
  logic [31:0]  dbData;

  xillylite_regfile_if bus();

  xillylite_regfile #(
    .ADDR_BITS  (5),
    .NUM_IRQ    (8),
    .NUM_STATUS (4),
    .ID_VALUE   (ID_VAL)
  ) dut (
    .i_user_clk       (clk),
    .i_user_rst_n     (rstN),
    .bus              (bus),
    .i_irq_event      (irqEvent),
    .i_status_in      (statusIn),
    .o_doorbell_pulse (dbPulse),
    .o_doorbell_data  (dbData)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] scratch [32];
  logic [7:0]  mIstat, mIen;
  logic [31:0] mDbell, expRd;
  logic        expPulse, expIrq;
  logic [31:0] sbQueue [$];
  logic        rdValid = 1'b0;

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model of what a read of this byte address returns, from the register map.
  function automatic logic [31:0] modelRead(input logic [31:0] addr);
    int w;
    w = int'(addr[6:2]);
    if (!addr[7]) return scratch[w];
    case (w)
      0:       return ID_VAL;
      1:       return {24'h0, mIstat};
      2:       return {24'h0, mIen};
      3:       return mDbell;
      4, 5, 6, 7: return statusIn[32*(w-4) +: 32];
      default: return 32'h0;
    endcase
  endfunction

  task automatic checkOutput();
    checkVal("irq", {31'h0, bus.user_irq}, {31'h0, expIrq});
    checkVal("doorbellPulse", {31'h0, dbPulse}, {31'h0, expPulse});
    checkVal("doorbellData", dbData, mDbell);
    checkVal("rdDataHold", bus.user_rd_data, expRd);
  endtask

  task automatic applyStimulus(input logic rst, input logic wren, input logic [3:0] strb,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic rden, input logic [7:0] ev);
    int w;
    logic pg;
    logic [31:0] lm;
    rstN = rst;
    bus.user_wren = wren;  bus.user_wstrb = strb;  bus.user_addr = addr;
    bus.user_wr_data = wdata;  bus.user_rden = rden;  irqEvent = ev;
    w  = int'(addr[6:2]);
    pg = addr[7];
    for (int b = 0; b < 4; b++) lm[8*b +: 8] = {8{strb[b]}};
    if (rst) begin
      if (rden) begin
        expRd = modelRead(addr);
        sbQueue.push_back(expRd);
      end
      expPulse = wren && pg && (w == 3) && (strb != 4'h0);
      if (wren && !pg) scratch[w] = (scratch[w] & ~lm) | (wdata & lm);
      if (wren && pg && w == 1) mIstat = mIstat & ~(wdata[7:0] & lm[7:0]);
      mIstat = mIstat | ev;
      if (wren && pg && w == 2) mIen = (mIen & ~lm[7:0]) | (wdata[7:0] & lm[7:0]);
      if (wren && pg && w == 3) mDbell = (mDbell & ~lm) | (wdata & lm);
      expIrq = |(mIstat & mIen);
    end else begin
      mIstat = 8'h0;  mIen = 8'h0;  mDbell = 32'h0;
      expPulse = 1'b0;  expIrq = 1'b0;  expRd = 32'h0;
    end
    @(posedge clk);
    #1;
    checkOutput();
    bus.user_wren = 1'b0;  bus.user_rden = 1'b0;  irqEvent = 8'h0;
  endtask

  task automatic doWrite(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    applyStimulus(1'b1, 1'b1, strb, addr, data, 1'b0, 8'h0);
  endtask

  task automatic doRead(input logic [31:0] addr);
    applyStimulus(1'b1, 1'b0, 4'h0, addr, 32'h0, 1'b1, 8'h0);
  endtask

  task automatic doIdle(input logic [7:0] ev);
    applyStimulus(1'b1, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, ev);
  endtask

  always @(posedge clk) rdValid <= bus.user_rden && rstN;

  // Monitor: every cycle that follows an accepted read pops one expected word.
  always @(negedge clk) begin
    if (rdValid) begin
      if (sbQueue.size() == 0) begin
        checkVal("sbUnderflow", 32'h1, 32'h0);
      end else begin
        checkVal("readData", bus.user_rd_data, sbQueue.pop_front());
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] a, d;
    rstN = 1'b0;
    bus.user_addr = '0;  bus.user_wren = 1'b0;  bus.user_wstrb = '0;
    bus.user_wr_data = '0;  bus.user_rden = 1'b0;  irqEvent = '0;
    statusIn = {$urandom, $urandom, $urandom, $urandom};
    mIstat = 8'h0;  mIen = 8'h0;  mDbell = 32'h0;  expRd = 32'h0;
    expPulse = 1'b0;  expIrq = 1'b0;
    @(posedge clk);  #1;
    $display("[TB] reset phase");
    applyStimulus(1'b0, 1'b1, 4'hF, 32'h0000_008C, 32'h1234_5678, 1'b1, 8'hFF);
    applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 8'h0);

    for (int i = 0; i < 32; i++) doWrite(32'(i * 4), $urandom, 4'hF);

    $display("[TB] directed: byte lanes");
    doWrite(32'h0000_007C, 32'hA5A5_1234, 4'b0101);
    doRead(32'h0000_007C);
    checkVal("laneMerge", scratch[31] & 32'h00FF_00FF, 32'h00A5_0034);

    $display("[TB] directed: depth and page decode");
    doWrite(32'h0000_000C, 32'hCAFE_F00D, 4'hF);
    doRead(32'h0000_000C);
    doRead(32'h0000_010C);
    doRead(32'hFFFF_FE0C);

    $display("[TB] directed: interrupt");
    doWrite(32'h0000_0088, 32'h0000_0001, 4'hF);
    doIdle(8'h01);
    doIdle(8'h00);
    doWrite(32'h0000_0084, 32'h0000_0001, 4'hF);
    doIdle(8'h00);

    $display("[TB] directed: event versus W1C collision");
    doIdle(8'h04);
    applyStimulus(1'b1, 1'b1, 4'h1, 32'h0000_0084, 32'h0000_0004, 1'b1, 8'h04);
    doRead(32'h0000_0084);
    checkVal("collisionModel", {31'h0, mIstat[2]}, 32'h1);

    $display("[TB] directed: doorbell, status, ID");
    doWrite(32'h0000_008C, 32'hDEAD_BEEF, 4'hF);
    doIdle(8'h00);
    statusIn[63:32] = 32'h0000_0055;
    doRead(32'h0000_0094);
    doRead(32'h0000_0080);
    doRead(32'h0000_00A0);

    $display("[TB] directed: reset mid-operation");
    doWrite(32'h0000_0088, 32'h0000_00FF, 4'hF);
    doIdle(8'h3C);
    doWrite(32'h0000_0040, 32'h1357_9BDF, 4'hF);
    doRead(32'h0000_0040);
    applyStimulus(1'b0, 1'b1, 4'hF, 32'h0000_0040, 32'h0, 1'b1, 8'hFF);
    doRead(32'h0000_0040);
    doRead(32'h0000_0084);
    doRead(32'h0000_0088);

    $display("[TB] random phase");
    for (int i = 0; i < 400; i++) begin
      a = $urandom;
      if ($urandom_range(0, 1) == 1) a[6:5] = 2'b00;
      d = $urandom;
      if (i % 25 == 0) statusIn = {$urandom, $urandom, $urandom, $urandom};
      applyStimulus(($urandom_range(0, 49) != 0), ($urandom_range(0, 1) == 1),
                    4'($urandom), a, d, ($urandom_range(0, 1) == 1),
                    ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h0);
    end
    doIdle(8'h0);
    doIdle(8'h0);
    checkVal("sbDrained", 32'(sbQueue.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
